spi_agc_responder: RTL
======================

# spi_agc_responder

Register-file responder for the 3-wire AGC SPI link: the far-end counterpart of the AGC SPI initiator. It samples SCLK, CS and SDIO with `main_clk`, decodes 16-bit write/read frames and updates an internal gain register file. Read frames drive the register contents back on the shared SDIO line through an external IOBUF.

It serves two roles:
- loopback/emulation target on a second FPGA;
- in-system model of the gain device for bring-up.

## Interface
Parameters:
- `NUM_REGS`, 8, number of 8-bit registers; legal range 2..128.
- `REG_RST_VAL`, 8'h00, reset value of every register.

Ports:
- `main_clk` in 1: system clock; must be ≥ 8× SCLK.
- `reg_reset` in 1: reset, synchronous, active-high.
- `spi_sclk` in 1: SPI clock from the initiator; asynchronous; idles low.
- `spi_cs_n` in 1: chip select, active-low; asynchronous.
- `spi_sdi` in 1: SDIO input, from IOBUF `O`.
- `spi_sdo` out 1: SDIO output data, to IOBUF `I`.
- `spi_sdo_t` out 1: IOBUF `T`; 1 = tristate, 0 = drive.
- `regs_out` out 8*NUM_REGS: flat register file; register n occupies bits [8n+7:8n].
- `wr_stb` out 1: one-cycle pulse when a register is written.
- `wr_addr` out 7: address of the last write.
- `frame_err` out 1: one-cycle pulse when a frame aborts.
- `busy` out 1: high while CS is low, as seen after synchronization.

## Operation
- **Input synchronization:** `spi_sclk`, `spi_cs_n` and `spi_sdi` each pass through a 2-flop synchronizer followed by one edge-detect flop. This produces `sclk_rise`, `sclk_fall`, `cs_fall` and `cs_rise`.
- **Frame format:** 16 bits, MSB first, sampled on SCLK rising edge.
  - bit15 = R1W0 (1 = read).
  - bits14:8 = addr[6:0].
  - bits7:0 = data.
- **FSM states:** IDLE, CMD, WR_DATA, RD_DATA, WAIT_CS.
  - IDLE → CMD on `cs_fall`; bit counter cleared.
  - CMD: shift 8 bits. After the 8th `sclk_rise`, go to RD_DATA if R1W0 = 1, else WR_DATA.
  - WR_DATA: shift 8 bits. On the 8th `sclk_rise`, go to WAIT_CS and commit the write.
  - RD_DATA: load `shift_out` with `regs[addr]`, or 8'h00 if addr ≥ NUM_REGS.
    - On each `sclk_fall`, drive the current MSB on `spi_sdo` with `spi_sdo_t` = 0, then shift left.
    - After the 8th `sclk_rise` of the data phase, go to WAIT_CS.
  - WAIT_CS: extra SCLK edges are ignored. `cs_rise` → IDLE.
- **Write commit:** if addr < NUM_REGS:
  - `regs[addr]` ← data;
  - `wr_addr` ← addr;
  - `wr_stb` = 1 for one cycle.
  
  If addr ≥ NUM_REGS, the write is silently dropped: no strobe, no error.
- **Abort:** `cs_rise` in CMD, WR_DATA or RD_DATA gives:
  - `frame_err` pulse;
  - no register change;
  - `spi_sdo_t` = 1;
  - return to IDLE.
- **SDIO release:** `spi_sdo_t` returns to 1 on `cs_rise` in any state. It is never 0 outside RD_DATA or WAIT_CS-after-read.
- **Simultaneous events:** if `cs_rise` and `sclk_rise` occur in the same cycle, `cs_rise` wins. A frame whose 16th edge coincides with CS rise is aborted.
- **Reset:** `reg_reset` applies at any time, including mid-frame. FSM goes to IDLE, all outputs take their reset values and the frame is discarded.

## Timing
- **Reset values:**
  - `regs_out` = {NUM_REGS{REG_RST_VAL}};
  - `spi_sdo` = 0;
  - `spi_sdo_t` = 1;
  - `wr_stb` = 0, `wr_addr` = 0, `frame_err` = 0, `busy` = 0.
- **Input latency:** each pin edge is detected 3 `main_clk` cycles after it arrives.
- **Write latency:** `wr_stb` and the `regs_out` update appear on the `main_clk` edge after the 16th `sclk_rise` detection, 4 cycles after the pin edge. Both occur in the same cycle.
- **Read output:** `spi_sdo` and `spi_sdo_t` are registered and change 4 cycles after the SCLK falling pin edge.
  - The initiator samples read data on the next rising edge.
  - The first read bit (bit7) is driven on the falling edge that follows the 8th rising edge.
- **busy:** rises 3 cycles after the CS fall pin edge and falls 3 cycles after the CS rise pin edge.

## Configuration
- `SPI_AGC_RESP_READBACK_EN` defined: read frames are supported as described above.
- Not defined:
  - RD_DATA is not entered; a read command goes to WAIT_CS after the command phase;
  - `spi_sdo_t` is tied to 1 and `spi_sdo` to 0;
  - read frames change no state and never raise `frame_err` unless aborted during CMD.

## Structure
- **Shared package `spi_agc_pkg`:**
  - FSM state enum;
  - FRAME_BITS = 16, CMD_BITS = 8, ADDR_W = 7;
  - R1W0 bit index = 15.
- **Sub-module `spi_agc_sync_edge`:** 2-flop synchronizer plus edge detect, with rise/fall outputs. Instantiated 3 times; `spi_sdi` uses only the synchronized output.

## Test plan
- **Write:** write addr 0x01 data 0xA5 at SCLK = main_clk/16.
  - `wr_stb` pulses once with `wr_addr` = 1.
  - `regs_out[15:8]` = 0xA5; other registers unchanged.
- **Readback:** with READBACK_EN, write 0x3C to addr 0x02, then read addr 0x02.
  - SDIO carries 0,0,1,1,1,1,0,0 during the data phase.
  - `spi_sdo_t` = 0 only from the 8th falling edge until CS rise.
- **Out-of-range:** write 0xFF to addr 0x7F with NUM_REGS = 8.
  - No `wr_stb`; `regs_out` unchanged.
  - A read of 0x7F returns 0x00.
- **Abort:** raise CS after 11 SCLK edges of a write.
  - `frame_err` pulses once; no `wr_stb`.
  - A following full write to addr 0 with 0x12 succeeds.
- **Reset mid-read:** assert `reg_reset` in RD_DATA.
  - Next cycle: `spi_sdo_t` = 1 and all registers = REG_RST_VAL.
  - A subsequent frame decodes correctly.
- **Macro off:** read addr 0x01 with `SPI_AGC_RESP_READBACK_EN` undefined.
  - `spi_sdo_t` stays 1 throughout.
  - No `wr_stb`, no `frame_err`.

Source files
------------

// File: rtl/spi_agc_pkg.sv
// spi_agc_pkg: shared frame constants and FSM state type
// for the AGC SPI responder.
package spi_agc_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CMD_BITS   = 8;
    localparam int ADDR_W     = 7;
    localparam int RW_BIT     = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_WAIT_CS
    } state_e;

endpackage

// File: rtl/spi_agc_sync_edge.sv
// spi_agc_sync_edge: 2-flop synchronizer plus registered edge detect.
// Ports: clk, rst (sync, active-high), din -> dout (level), rise, fall.
module spi_agc_sync_edge
    import spi_agc_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, s3_q, rise_q, fall_q;
    logic s1_d, s2_d, s3_d, rise_d, fall_d;

    // dout is delayed one flop so it lines up with rise/fall.
    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        s3_d   = s2_q;
        rise_d = s2_q & ~s3_q;
        fall_d = ~s2_q & s3_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            s3_q   <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout = s3_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/spi_agc_responder.sv
// spi_agc_responder: 3-wire SPI register-file responder. Ports: main_clk,
// reg_reset (sync, high), spi_sclk/spi_cs_n/spi_sdi in; spi_sdo/spi_sdo_t to
// IOBUF; regs_out flat regs; wr_stb/wr_addr write report; frame_err; busy.
// SPI_AGC_RESP_READBACK_EN enables read frames driving SDIO.
module spi_agc_responder
    import spi_agc_pkg::*;
#(
    parameter int         NUM_REGS    = 8,
    parameter logic [7:0] REG_RST_VAL = 8'h00
) (
    input  logic                  main_clk,
    input  logic                  reg_reset,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_sdi,
    output logic                  spi_sdo,
    output logic                  spi_sdo_t,
    output logic [8*NUM_REGS-1:0] regs_out,
    output logic                  wr_stb,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int         IW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] NREG8    = 8'(NUM_REGS);
    localparam logic [2:0] CMD_LAST = 3'(CMD_BITS - 1);
    localparam logic [2:0] DAT_LAST = 3'(FRAME_BITS - CMD_BITS - 1);
    localparam int         RW_POS   = RW_BIT - (FRAME_BITS - CMD_BITS);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic cs_rise, cs_fall, cs_lvl;
    logic sdi_s, sdi_rise_unused, sdi_fall_unused;

    spi_agc_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(main_clk), .rst(reg_reset), .din(spi_sclk),
        .dout(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_agc_sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk(main_clk), .rst(reg_reset), .din(spi_cs_n),
        .dout(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_agc_sync_edge #(.RST_VAL(1'b0)) u_sdi (
        .clk(main_clk), .rst(reg_reset), .din(spi_sdi),
        .dout(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
    );

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [6:0]        sh_q, sh_d;
    logic [7:0]        sh_nx;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        regs_d [NUM_REGS];
    logic              wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              frame_err_q, frame_err_d;
`ifdef SPI_AGC_RESP_READBACK_EN
    logic              sdo_q, sdo_d;
    logic              sdo_t_q, sdo_t_d;
    logic [7:0]        shout_q, shout_d;
`endif

    function automatic logic in_rng(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NREG8;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        addr_d      = addr_q;
        regs_d      = regs_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
        sh_nx       = {sh_q, sdi_s};
`ifdef SPI_AGC_RESP_READBACK_EN
        sdo_d       = sdo_q;
        sdo_t_d     = sdo_t_q;
        shout_d     = shout_q;
`endif
        // CS release outranks any SCLK edge seen in the same cycle.
        if (cs_rise) begin
            state_d     = ST_IDLE;
            frame_err_d = (state_q == ST_CMD) | (state_q == ST_WR_DATA)
                        | (state_q == ST_RD_DATA);
`ifdef SPI_AGC_RESP_READBACK_EN
            sdo_d       = 1'b0;
            sdo_t_d     = 1'b1;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d = ST_CMD;
                        cnt_d   = '0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        sh_d  = sh_nx[6:0];
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == CMD_LAST) begin
                            cnt_d  = '0;
                            addr_d = sh_nx[ADDR_W-1:0];
                            if (sh_nx[RW_POS]) begin
`ifdef SPI_AGC_RESP_READBACK_EN
                                state_d = ST_RD_DATA;
                                shout_d = in_rng(sh_nx[ADDR_W-1:0])
                                        ? regs_q[sh_nx[IW-1:0]] : 8'h00;
`else
                                state_d = ST_WAIT_CS;
`endif
                            end else begin
                                state_d = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (sclk_rise) begin
                        sh_d  = sh_nx[6:0];
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == DAT_LAST) begin
                            state_d = ST_WAIT_CS;
                            if (in_rng(addr_q)) begin
                                regs_d[addr_q[IW-1:0]] = sh_nx;
                                wr_stb_d  = 1'b1;
                                wr_addr_d = addr_q;
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
`ifdef SPI_AGC_RESP_READBACK_EN
                    if (sclk_fall) begin
                        sdo_d   = shout_q[7];
                        sdo_t_d = 1'b0;
                        shout_d = {shout_q[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == DAT_LAST) state_d = ST_WAIT_CS;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
                ST_WAIT_CS: begin
                    state_d = ST_WAIT_CS;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge main_clk) begin
        if (reg_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            addr_q      <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RST_VAL;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
`ifdef SPI_AGC_RESP_READBACK_EN
            sdo_q       <= 1'b0;
            sdo_t_q     <= 1'b1;
            shout_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            addr_q      <= addr_d;
            regs_q      <= regs_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
`ifdef SPI_AGC_RESP_READBACK_EN
            sdo_q       <= sdo_d;
            sdo_t_q     <= sdo_t_d;
            shout_q     <= shout_d;
`endif
        end
    end

`ifdef SPI_AGC_RESP_READBACK_EN
    assign spi_sdo   = sdo_q;
    assign spi_sdo_t = sdo_t_q;
`else
    logic unused_sclk_fall;
    assign unused_sclk_fall = sclk_fall;
    assign spi_sdo   = 1'b0;
    assign spi_sdo_t = 1'b1;
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_out[8*g +: 8] = regs_q[g];
    end

    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;
    assign busy      = ~cs_lvl;

endmodule
